// File: rtl/vga_score_digits.sv
// vga_score_digits
//   Converts a binary score to BCD with a sequential double-dabble engine.
//   It then answers per-pixel "is this pixel lit" polls for a row of DIGITS
//   scaled seven-segment glyphs.
//
// Build option:
//   SCORE_LZB_EN  when defined, digits left of the first non-zero digit render
//                 blank. The least-significant digit always renders.
//                 The `digits` output is unaffected.
//
// Ports:
//   clk, reset        pixel clock; asynchronous active-high reset
//   load, value       one-cycle request to convert `value` (ignored while busy)
//   busy              conversion in progress (SHIFT or COMMIT)
//   overflow          last committed value exceeded 10^DIGITS-1
//   digits            committed BCD, digit 0 (most significant) in top nibble
//   ObjectX/ObjectY   glyph-row origin in pixels
//   ObjectScale       unit size = 1 << ObjectScale pixels
//   PollX/PollY       polled pixel; Hit follows three cycles later
//   Hit               polled pixel lies on a lit segment
module vga_score_digits #(
  parameter int DIGITS  = 3,
  parameter int VALUE_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [VALUE_W-1:0]  value,
  output logic                busy,
  output logic                overflow,
  output logic [4*DIGITS-1:0] digits,
  input  logic [10:0]         ObjectX,
  input  logic [9:0]          ObjectY,
  input  logic [2:0]          ObjectScale,
  input  logic [9:0]          PollX,
  input  logic [9:0]          PollY,
  output logic                Hit
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int EXT_X = 4 * DIGITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Segment bits ordered {a,b,c,d,e,f,g}; BCD codes 10-15 stay dark.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Maps a (col,row) unit inside a 4x5 cell onto the segments covering it.
  // Rows are already bounded to 0..4, so "row >= 2" means rows 2..4.
  function automatic logic cell_lit(input logic [6:0] seg, input logic [1:0] col,
                                    input logic [2:0] row);
    logic lit;
    lit = 1'b0;
    if (col != 2'd3) begin
      if (seg[6] && row == 3'd0)                 lit = 1'b1;
      if (seg[5] && col == 2'd2 && row <= 3'd2)  lit = 1'b1;
      if (seg[4] && col == 2'd2 && row >= 3'd2)  lit = 1'b1;
      if (seg[3] && row == 3'd4)                 lit = 1'b1;
      if (seg[2] && col == 2'd0 && row >= 3'd2)  lit = 1'b1;
      if (seg[1] && col == 2'd0 && row <= 3'd2)  lit = 1'b1;
      if (seg[0] && row == 3'd2)                 lit = 1'b1;
    end
    return lit;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    bcd_d    = bcd_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    adj      = dabble_adjust(bcd_q);
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          val_d   = value;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A bit leaving the top nibble means the value needs another digit.
        bcd_d   = {adj[BCD_W-2:0], val_q[VALUE_W-1]};
        carry_d = carry_q | adj[BCD_W-1];
        val_d   = val_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (carry_q || (bcd_q[BCD_W-1 -: 4] > 4'd9)) begin
          digits_d = {DIGITS{4'h9}};
          ovf_d    = 1'b1;
        end else begin
          digits_d = bcd_q;
          ovf_d    = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      val_q    <= '0;
      bcd_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      bcd_q    <= bcd_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign digits   = digits_q;
  assign overflow = ovf_q;

  // ---------------------------------------------------------------------------
  // Render pipeline S1: offsets from the glyph origin
  // ---------------------------------------------------------------------------
  logic signed [11:0] dx_p1_d, dx_p1_q;
  logic signed [11:0] dy_p1_d, dy_p1_q;
  logic               in_p1_d, in_p1_q;
  logic [2:0]         scale_p1_d, scale_p1_q;
  logic               vld_p1_d, vld_p1_q;

  always_comb begin
    dx_p1_d    = signed'({2'b00, PollX} - {1'b0, ObjectX});
    dy_p1_d    = signed'({2'b00, PollY} - {2'b00, ObjectY});
    in_p1_d    = ~dx_p1_d[11] & ~dy_p1_d[11];
    // Scale travels with its poll so mid-frame changes stay per-pixel coherent.
    scale_p1_d = ObjectScale;
    vld_p1_d   = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Render pipeline S2: unit coordinates and extent check
  // ---------------------------------------------------------------------------
  logic [11:0] ux, uy;
  logic [2:0]  idx_p2_d, idx_p2_q;
  logic [1:0]  col_p2_d, col_p2_q;
  logic [2:0]  row_p2_d, row_p2_q;
  logic        in_p2_d, in_p2_q;
  logic        vld_p2_d, vld_p2_q;

  always_comb begin
    ux       = $unsigned(dx_p1_q) >> scale_p1_q;
    uy       = $unsigned(dy_p1_q) >> scale_p1_q;
    in_p2_d  = in_p1_q && (ux < 12'(EXT_X)) && (uy < 12'd5);
    idx_p2_d = ux[4:2];
    col_p2_d = ux[1:0];
    row_p2_d = uy[2:0];
    vld_p2_d = vld_p1_q;
  end

  // ---------------------------------------------------------------------------
  // Render pipeline S3: digit select, blanking, segment decode
  // ---------------------------------------------------------------------------
  logic [3:0]        nib;
  logic [DIGITS-1:0] blank;
  logic              lead;
  logic              hit_d, hit_q;

  always_comb begin
    nib   = '0;
    blank = '0;
    lead  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_p2_q == 3'(i)) nib = digits_q[4*(DIGITS-1-i) +: 4];
      lead = lead & (digits_q[4*(DIGITS-1-i) +: 4] == 4'd0);
`ifdef SCORE_LZB_EN
      blank[i] = lead && (i < DIGITS - 1);
`else
      blank[i] = 1'b0;
`endif
    end
    hit_d = vld_p2_q && in_p2_q && !blank[idx_p2_q]
            && cell_lit(seg_pattern(nib), col_p2_q, row_p2_q);
  end

  // Pipeline data registers carry no reset; the valid flags and Hit do.
  always_ff @(posedge clk) begin
    dx_p1_q    <= dx_p1_d;
    dy_p1_q    <= dy_p1_d;
    in_p1_q    <= in_p1_d;
    scale_p1_q <= scale_p1_d;
    idx_p2_q   <= idx_p2_d;
    col_p2_q   <= col_p2_d;
    row_p2_q   <= row_p2_d;
    in_p2_q    <= in_p2_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      hit_q    <= hit_d;
    end
  end

  assign Hit = hit_q;

endmodule

// File: tb/tb_vga_score_digits.sv
module tb_vga_score_digits;

  localparam int DIGITS  = 3;
  localparam int VALUE_W = 10;
`ifdef SCORE_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                load;
  logic [VALUE_W-1:0]  value;
  logic                busy;
  logic                overflow;
  logic [4*DIGITS-1:0] digits;
  logic [10:0]         ObjectX;
  logic [9:0]          ObjectY;
  logic [2:0]          ObjectScale;
  logic [9:0]          PollX;
  logic [9:0]          PollY;
  logic                Hit;

  vga_score_digits #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy), .overflow(overflow), .digits(digits),
    .ObjectX(ObjectX), .ObjectY(ObjectY), .ObjectScale(ObjectScale),
    .PollX(PollX), .PollY(PollY), .Hit(Hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // 3x5 bitmaps, rows top to bottom, leftmost column is the MSB of each row.
  function automatic logic [14:0] glyph(input int d);
    case (d)
      0: return 15'b111_101_101_101_111;
      1: return 15'b001_001_001_001_001;
      2: return 15'b111_001_111_100_111;
      3: return 15'b111_001_111_001_111;
      4: return 15'b101_101_111_001_001;
      5: return 15'b111_100_111_001_111;
      6: return 15'b111_100_111_101_111;
      7: return 15'b111_001_001_001_001;
      8: return 15'b111_101_111_101_111;
      default: return 15'b111_101_111_001_111;
    endcase
  endfunction

  function automatic int shown_val(input int score);
    return (score > p10(DIGITS) - 1) ? p10(DIGITS) - 1 : score;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int score);
    logic [4*DIGITS-1:0] r;
    int s;
    s = shown_val(score);
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*(DIGITS-1-i) +: 4] = 4'((s / p10(DIGITS-1-i)) % 10);
    return r;
  endfunction

  function automatic logic model_hit(input int px, input int py, input int ox,
                                     input int oy, input int sc, input int score);
    int dx, dy, ux, uy, d, c, w, s;
    logic [14:0] g;
    dx = px - ox;
    dy = py - oy;
    if (dx < 0 || dy < 0) return 1'b0;
    ux = dx / (1 << sc);
    uy = dy / (1 << sc);
    if (ux >= 4*DIGITS - 1 || uy >= 5) return 1'b0;
    d = ux / 4;
    c = ux % 4;
    if (c == 3) return 1'b0;
    s = shown_val(score);
    w = p10(DIGITS - 1 - d);
    if (LZB && d < DIGITS - 1 && s < w) return 1'b0;
    g = glyph((s / w) % 10);
    return g[14 - (uy*3 + c)];
  endfunction

  typedef struct packed {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [10:0] ox;
    logic [9:0]  oy;
    logic [2:0]  sc;
  } poll_t;

  poll_t h1, h2;
  int    m_busy  = 0;
  int    m_score = 0;
  int    m_pend  = 0;
  int    m_run   = 0;
  logic  m_hit   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy  <= 0;
      m_score <= 0;
      m_pend  <= 0;
      m_run   <= 0;
      m_hit   <= 1'b0;
    end else begin
      m_hit <= (m_run >= 2) ? model_hit(int'(h2.px), int'(h2.py), int'(h2.ox),
                                        int'(h2.oy), int'(h2.sc), m_score) : 1'b0;
      m_run <= (m_run < 10) ? m_run + 1 : m_run;
      if (m_busy == 0) begin
        if (load) begin
          m_pend <= int'(value);
          m_busy <= VALUE_W + 1;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) m_score <= m_pend;
      end
    end
    h2 <= h1;
    h1 <= '{PollX, PollY, ObjectX, ObjectY, ObjectScale};
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("hit_rst", Hit, 0);
      chk("busy_rst", busy, 0);
      chk("digits_rst", digits, 0);
      chk("ovf_rst", overflow, 0);
    end else begin
      chk("hit", Hit, m_hit);
      chk("busy", busy, (m_busy != 0));
      chk("digits", digits, to_bcd(m_score));
      chk("ovf", overflow, (m_score > p10(DIGITS) - 1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_bound", (n < 100), 1);
  endtask

  task automatic do_load(input int v, output int n);
    @(negedge clk);
    load  = 1'b1;
    value = VALUE_W'(v);
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
  endtask

  task automatic poll_lit(input string nm, input int x, input int y, input logic exp);
    @(negedge clk);
    PollX = 10'(x);
    PollY = 10'(y);
    repeat (3) @(posedge clk);
    #1;
    chk(nm, Hit, exp);
  endtask

  task automatic sweep(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        @(negedge clk);
        PollX = 10'(x);
        PollY = 10'(y);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int ox, oy;
    reset = 1'b1; load = 1'b0; value = '0;
    ObjectX = 11'd100; ObjectY = 10'd50; ObjectScale = 3'd2;
    PollX = '0; PollY = '0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_digits", digits, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_hit", Hit, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Score 0 at origin (100,50), unit 4 px.
    poll_lit("zero_rightmost_a", 132, 50, 1'b1);
    poll_lit("zero_leftmost_a", 100, 50, LZB ? 1'b0 : 1'b1);
    poll_lit("zero_gap", 112, 50, 1'b0);
    poll_lit("zero_center", 137, 60, 1'b0);
    sweep(96, 150, 46, 72);

    do_load(357, n);
    chk("busy_cycles_357", n, 11);
    chk("digits_357", digits, 12'h357);
    chk("ovf_357", overflow, 0);
    ObjectScale = 3'd1;
    sweep(96, 126, 48, 62);

    do_load(1023, n);
    chk("digits_1023", digits, 12'h999);
    chk("ovf_1023", overflow, 1);
    ObjectScale = 3'd2;
    poll_lit("nine_f_seg", 100, 54, 1'b1);
    poll_lit("nine_row3_col0", 100, 62, 1'b0);

    do_load(42, n);
    chk("digits_42", digits, 12'h042);
    chk("ovf_42", overflow, 0);
    sweep(98, 148, 48, 72);

    // Load requests on every cycle of a conversion are dropped.
    @(negedge clk);
    load = 1'b1; value = 10'd5;
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin
      value = VALUE_W'(900 + n);
      @(negedge clk);
      n++;
    end
    chk("storm_bound", (n < 100), 1);
    chk("storm_digits_5", digits, 12'h005);
    value = 10'd6;
    @(negedge clk);
    load = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_idle(n);
    chk("b2b_digits_6", digits, 12'h006);

    // Scale/bounds sweep showing "8" in the rightmost cell.
    do_load(8, n);
    chk("digits_8", digits, 12'h008);
    for (int s = 0; s < 4; s++) begin
      ox = 200 + 37 * s;
      oy = 100 + 11 * s;
      ObjectX = 11'(ox); ObjectY = 10'(oy); ObjectScale = 3'(s);
      poll_lit("g_seg", ox + (9 << s), oy + (2 << s), 1'b1);
      poll_lit("d_seg_last_px", ox + (8 << s), oy + (5 << s) - 1, 1'b1);
      poll_lit("gap_col", ox + (7 << s), oy, 1'b0);
      poll_lit("past_extent", ox + (11 << s), oy, 1'b0);
      poll_lit("neg_dx", ox - 1, oy, 1'b0);
      poll_lit("neg_dy", ox + (9 << s), oy - 1, 1'b0);
      poll_lit("below_row4", ox + (8 << s), oy + (5 << s), 1'b0);
      sweep(ox - 2, ox + (11 << s) + 1, oy - 2, oy + (5 << s) + 1);
    end

    // Reset during SHIFT aborts the conversion.
    do_load(123, n);
    chk("digits_123", digits, 12'h123);
    @(negedge clk);
    load = 1'b1; value = 10'd500;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_digits", digits, 0);
    chk("abort_hit", Hit, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_abort_digits", digits, 0);
    chk("post_abort_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
